// File: rtl/adder_share_ctrl_pkg.sv
// Shared definitions for the adder sharing controller: FSM states and
// operand slice geometry.
package adder_share_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam int HALF  = 16;
  localparam int SLICE = 32;

endpackage

// File: rtl/adder_share_ctrl_if.sv
// Requester/result bus plus the link to the external 16-bit adder.
// master = requesters and adder side, slave = the controller.
interface adder_share_ctrl_if
  import adder_share_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]       REQ;
  logic [NREQ-1:0]       WIDE;
  logic [SLICE*NREQ-1:0] OPA;
  logic [SLICE*NREQ-1:0] OPB;
  logic [NREQ-1:0]       CIN;
  logic [NREQ-1:0]       GNT;
  logic                  BUSY;
  logic                  DONE;
  logic [IDW-1:0]        RID;
  logic [SLICE-1:0]      RESULT;
  logic                  COUT;
  logic [HALF-1:0]       ADD_IN0;
  logic [HALF-1:0]       ADD_IN1;
  logic                  ADD_CIN;
  logic [HALF-1:0]       ADD_SUM;
  logic                  ADD_COUT;

  modport master (
    output REQ, WIDE, OPA, OPB, CIN, ADD_SUM, ADD_COUT,
    input  GNT, BUSY, DONE, RID, RESULT, COUT, ADD_IN0, ADD_IN1, ADD_CIN
  );

  modport slave (
    input  REQ, WIDE, OPA, OPB, CIN, ADD_SUM, ADD_COUT,
    output GNT, BUSY, DONE, RID, RESULT, COUT, ADD_IN0, ADD_IN1, ADD_CIN
  );

endinterface

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin search: first set request after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  int unsigned idx;

  always_comb begin
    gnt    = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(ptr) + i) % unsigned'(NREQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        winner   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one external 16-bit adder between NREQ requesters; 32-bit adds
// take two chained passes with the carry fed back through carry_q.
module adder_share_ctrl
  import adder_share_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input logic              CLK,
  input logic              RST,
  adder_share_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   rid_q;
  logic [SLICE-1:0] opa_q, opb_q;
  logic [SLICE-1:0] result_q;
  logic             cin_q, wide_q, carry_q;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDW-1:0]   arb_winner;
  logic             arb_any;
  int unsigned      wsel;

  logic             grant, busy, done, add_cin;
  logic [HALF-1:0]  add_in0, add_in1;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (bus.REQ),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .winner (arb_winner),
    .any    (arb_any)
  );

  assign wsel = 32'(arb_winner);

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    add_in0 = '0;
    add_in1 = '0;
    add_cin = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          grant   = 1'b1;
          busy    = 1'b1;
          state_d = S_LO;
        end
      end
      S_LO: begin
        busy    = 1'b1;
        add_in0 = opa_q[HALF-1:0];
        add_in1 = opb_q[HALF-1:0];
        add_cin = cin_q;
        state_d = wide_q ? S_HI : S_RESP;
      end
      S_HI: begin
        busy    = 1'b1;
        add_in0 = opa_q[SLICE-1:HALF];
        add_in1 = opb_q[SLICE-1:HALF];
        add_cin = carry_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset must force every output low even though these are combinational.
    if (RST) begin
      grant   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      add_in0 = '0;
      add_in1 = '0;
      add_cin = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      ptr_q    <= IDW'(NREQ - 1);
      rid_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cin_q    <= 1'b0;
      wide_q   <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            opa_q  <= bus.OPA[wsel*SLICE +: SLICE];
            opb_q  <= bus.OPB[wsel*SLICE +: SLICE];
            cin_q  <= bus.CIN[wsel];
            wide_q <= bus.WIDE[wsel];
            rid_q  <= arb_winner;
            ptr_q  <= arb_winner;
          end
        end
        S_LO: begin
          // Upper half cleared here so a narrow result reads back zero-extended.
          result_q <= {{(SLICE-HALF){1'b0}}, bus.ADD_SUM};
          carry_q  <= bus.ADD_COUT;
        end
        S_HI: begin
          result_q[SLICE-1:HALF] <= bus.ADD_SUM;
          carry_q                <= bus.ADD_COUT;
        end
        default: ;
      endcase
    end
  end

  assign bus.GNT     = grant ? arb_gnt : '0;
  assign bus.BUSY    = busy;
  assign bus.DONE    = done;
  assign bus.RID     = rid_q;
  assign bus.RESULT  = result_q;
  assign bus.COUT    = carry_q;
  assign bus.ADD_IN0 = add_in0;
  assign bus.ADD_IN1 = add_in1;
  assign bus.ADD_CIN = add_cin;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl with an ideal 16-bit adder attached
// and an arithmetic reference model for results, carries and grant order.
module tb_adder_share_ctrl;
  import adder_share_ctrl_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mptr  = NREQ - 1;

  adder_share_ctrl_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  adder_share_ctrl #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign {bus.ADD_COUT, bus.ADD_SUM} = 17'(bus.ADD_IN0) + 17'(bus.ADD_IN1) + 17'(bus.ADD_CIN);

  // {cout, result} from plain arithmetic
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic w);
    logic [32:0] s;
    logic [16:0] n;
    if (w) begin
      s = {1'b0, a} + {1'b0, b} + 33'(c);
    end else begin
      n = {1'b0, a[15:0]} + {1'b0, b[15:0]} + 17'(c);
      s = {n[16], 16'h0000, n[15:0]};
    end
    return s;
  endfunction

  function automatic int rr_next(input logic [NREQ-1:0] r, input int p);
    for (int j = 1; j <= NREQ; j++)
      if (r[(p + j) % NREQ]) return (p + j) % NREQ;
    return -1;
  endfunction

  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic w, input string name);
    logic [32:0] exp;
    logic [32:0] lo;
    int t;
    bit got;
    exp = model(a, b, c, w);
    lo  = model(a, b, c, 1'b0);
    @(posedge clk); #1;
    bus.OPA[k*32 +: 32] = a;
    bus.OPB[k*32 +: 32] = b;
    bus.CIN[k]  = c;
    bus.WIDE[k] = w;
    bus.REQ     = NREQ'(1 << k);
    got = 0;
    t = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.GNT != '0) begin got = 1; t = cyc; end
    end
    total++;
    if (!got || bus.GNT !== NREQ'(1 << k) || bus.BUSY !== 1'b1) begin
      bad++;
      $display("FAIL %s grant: gnt=%b busy=%b, want gnt=%b busy=1", name, bus.GNT, bus.BUSY, NREQ'(1 << k));
      bus.REQ = '0;
      return;
    end
    mptr = k;
    @(posedge clk); #1;
    bus.REQ = '0;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      if (i > 0) @(negedge clk);
      else @(negedge clk);
      if (bus.DONE === 1'b1) begin
        got = 1;
      end else if (cyc - t == 1) begin
        total++;
        if (bus.ADD_IN0 !== a[15:0] || bus.ADD_IN1 !== b[15:0] || bus.ADD_CIN !== c || bus.BUSY !== 1'b1) begin
          bad++;
          $display("FAIL %s lo_pass: in0=%h in1=%h cin=%b busy=%b, want %h %h %b 1",
                   name, bus.ADD_IN0, bus.ADD_IN1, bus.ADD_CIN, bus.BUSY, a[15:0], b[15:0], c);
        end
      end else if (w && cyc - t == 2) begin
        total++;
        if (bus.ADD_IN0 !== a[31:16] || bus.ADD_IN1 !== b[31:16] || bus.ADD_CIN !== lo[32] || bus.BUSY !== 1'b1) begin
          bad++;
          $display("FAIL %s hi_pass: in0=%h in1=%h cin=%b busy=%b, want %h %h %b 1",
                   name, bus.ADD_IN0, bus.ADD_IN1, bus.ADD_CIN, bus.BUSY, a[31:16], b[31:16], lo[32]);
        end
      end
    end
    total++;
    if (!got || (cyc - t) != (w ? 3 : 2)) begin
      bad++;
      $display("FAIL %s latency: got_done=%0d cycles=%0d, want done after %0d", name, got, cyc - t, w ? 3 : 2);
    end
    total++;
    if (bus.RESULT !== exp[31:0] || bus.COUT !== exp[32] || bus.RID !== IDW'(k)) begin
      bad++;
      $display("FAIL %s result: result=%h cout=%b rid=%0d, want %h %b %0d",
               name, bus.RESULT, bus.COUT, bus.RID, exp[31:0], exp[32], k);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.REQ = '1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (bus.GNT !== '0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: gnt=%b busy=%b done=%b, want 0 0 0", bus.GNT, bus.BUSY, bus.DONE);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.REQ = '0;
    mptr = NREQ - 1;
    @(negedge clk);
    total++;
    if (bus.GNT !== '0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.RID !== '0 || bus.RESULT !== '0 ||
        bus.COUT !== 1'b0 || bus.ADD_IN0 !== '0 || bus.ADD_IN1 !== '0 || bus.ADD_CIN !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: gnt=%b busy=%b done=%b rid=%0d result=%h cout=%b in0=%h in1=%h cin=%b, want all 0",
               bus.GNT, bus.BUSY, bus.DONE, bus.RID, bus.RESULT, bus.COUT, bus.ADD_IN0, bus.ADD_IN1, bus.ADD_CIN);
    end
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] mreq;
    logic [31:0] oa[NREQ];
    logic [31:0] ob[NREQ];
    logic [32:0] exp;
    int order[$];
    int dones[$];
    int ew, drop, raise;
    for (int k = 0; k < NREQ; k++) begin
      oa[k] = 32'(1000 + 7 * k);
      ob[k] = 32'(20 + k);
      bus.OPA[k*32 +: 32] = oa[k];
      bus.OPB[k*32 +: 32] = ob[k];
      bus.CIN[k]  = 1'b0;
      bus.WIDE[k] = 1'b0;
    end
    @(posedge clk); #1;
    mreq = '1;
    bus.REQ = mreq;
    for (int c = 0; c < 40 && dones.size() < 4; c++) begin
      @(negedge clk);
      drop = -1;
      raise = -1;
      if (bus.GNT != '0) begin
        ew = rr_next(mreq, mptr);
        total++;
        if (bus.GNT !== NREQ'(1 << ew)) begin
          bad++;
          $display("FAIL rr_grant: gnt=%b, want %b", bus.GNT, NREQ'(1 << ew));
        end
        mptr = ew;
        order.push_back(ew);
        drop = ew;
      end
      if (bus.DONE === 1'b1) begin
        dones.push_back(cyc);
        exp = model(oa[bus.RID], ob[bus.RID], 1'b0, 1'b0);
        total++;
        if (bus.RESULT !== exp[31:0] || bus.COUT !== exp[32]) begin
          bad++;
          $display("FAIL rr_result: rid=%0d result=%h cout=%b, want %h %b", bus.RID, bus.RESULT, bus.COUT, exp[31:0], exp[32]);
        end
        if (order.size() < 4) raise = int'(bus.RID);
      end
      @(posedge clk); #1;
      if (drop >= 0) mreq[drop] = 1'b0;
      if (raise >= 0) mreq[raise] = 1'b1;
      bus.REQ = mreq;
    end
    bus.REQ = '0;
    total++;
    if (dones.size() != 4 || order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      bad++;
      $display("FAIL rr_order: grants=%0d dones=%0d, want order 0,1,0,1 with 4 dones", order.size(), dones.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        total++;
        if (dones[i] - dones[i-1] != 3) begin
          bad++;
          $display("FAIL rr_spacing: done gap=%0d, want 3", dones[i] - dones[i-1]);
        end
      end
    end
  endtask

  task automatic test_narrow;
    run_op(0, 32'd10, 32'd20, 1'b0, 1'b0, "narrow_basic");
    run_op(1, 32'd101, 32'd20000, 1'b1, 1'b0, "narrow_cin");
    run_op(0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, "narrow_carry");
    run_op(1, 32'hABCD1234, 32'h55550001, 1'b0, 1'b0, "narrow_upper_ignored");
    @(negedge clk);
    total++;
    if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 || bus.ADD_IN0 !== '0 || bus.RESULT !== 32'h00001235 || bus.RID !== IDW'(1)) begin
      bad++;
      $display("FAIL after_done: done=%b busy=%b in0=%h result=%h rid=%0d, want 0 0 0 00001235 1",
               bus.DONE, bus.BUSY, bus.ADD_IN0, bus.RESULT, bus.RID);
    end
  endtask

  task automatic test_wide;
    run_op(0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b1, "wide_midcarry");
    run_op(1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, "wide_wrap");
    run_op(0, 32'h7FFF8000, 32'h00008000, 1'b0, 1'b1, "wide_chain");
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++)
      run_op(int'($urandom_range(0, NREQ - 1)), $urandom, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_reset_abort;
    int t;
    bit got;
    int ew;
    bus.OPA[31:0] = 32'h1234FFFF;
    bus.OPB[31:0] = 32'h00010001;
    bus.CIN[0]  = 1'b0;
    bus.WIDE[0] = 1'b1;
    @(posedge clk); #1;
    bus.REQ = 2'b01;
    got = 0;
    t = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.GNT != '0) begin got = 1; t = cyc; end
    end
    @(posedge clk); #1;
    bus.REQ = '0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (!got || cyc - t != 2 || bus.DONE !== 1'b0) begin
      bad++;
      $display("FAIL abort_setup: granted=%0d cycles=%0d done=%b, want granted in HI cycle 2", got, cyc - t, bus.DONE);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mptr = NREQ - 1;
    @(negedge clk);
    total++;
    if (bus.GNT !== '0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.RID !== '0 || bus.RESULT !== '0 ||
        bus.COUT !== 1'b0 || bus.ADD_IN0 !== '0 || bus.ADD_IN1 !== '0 || bus.ADD_CIN !== 1'b0) begin
      bad++;
      $display("FAIL abort_outputs: gnt=%b busy=%b done=%b rid=%0d result=%h cout=%b in0=%h in1=%h cin=%b, want all 0",
               bus.GNT, bus.BUSY, bus.DONE, bus.RID, bus.RESULT, bus.COUT, bus.ADD_IN0, bus.ADD_IN1, bus.ADD_CIN);
    end
    got = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.DONE === 1'b1) got = 1;
    end
    total++;
    if (got) begin
      bad++;
      $display("FAIL abort_no_done: done=1, want 0");
    end
    bus.OPA[63:32] = 32'd5;
    bus.OPB[63:32] = 32'd6;
    bus.CIN[1]  = 1'b0;
    bus.WIDE[1] = 1'b0;
    bus.OPA[31:0] = 32'd40;
    bus.OPB[31:0] = 32'd2;
    bus.WIDE[0] = 1'b0;
    @(posedge clk); #1;
    bus.REQ = 2'b11;
    ew = rr_next(2'b11, mptr);
    @(negedge clk);
    total++;
    if (bus.GNT !== NREQ'(1 << ew)) begin
      bad++;
      $display("FAIL abort_regrant: gnt=%b, want %b", bus.GNT, NREQ'(1 << ew));
    end
    @(posedge clk); #1;
    bus.REQ = '0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.DONE !== 1'b1 || bus.RESULT !== 32'd42 || bus.RID !== IDW'(ew)) begin
      bad++;
      $display("FAIL abort_followup: done=%b result=%0d rid=%0d, want 1 42 %0d", bus.DONE, bus.RESULT, bus.RID, ew);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.REQ  = '0;
    bus.WIDE = '0;
    bus.CIN  = '0;
    bus.OPA  = '0;
    bus.OPB  = '0;
    test_reset();
    test_round_robin();
    test_narrow();
    test_wide();
    test_random();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
